dmem_arbiter: RTL

//  Shares the single-port data memory between the pipeline MEM stage (CPU) and an external loader/DMA requester.

---
 rtl/dmem_arbiter_if.sv | 56 +++++
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter.
//   slave  : arbiter view (takes CPU/DMA requests and read data, drives grants and memory strobes)
//   master : requester/memory side (drives CPU/DMA requests and mem_rdata)
// Signals:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   CPU MEM-stage access
//   cpu_stall/cpu_rvalid/cpu_rdata      CPU stall and read return
//   dma_req/dma_we/dma_addr/dma_wdata   DMA access, held stable until dma_gnt
//   dma_burst                           DMA wants to keep ownership
//   dma_gnt/dma_rvalid/dma_rdata        DMA grant and read return
//   mem_re/mem_we/mem_addr/mem_wdata    single-port data memory access
//   mem_rdata                           memory read data, one cycle after mem_re
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_burst;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_burst,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_re, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_burst,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_re, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU MEM stage
// and an external loader/DMA requester.
//   - CPU has fixed priority; a DMA request denied MAX_WAIT cycles in a row is
//     forced ahead of the CPU for exactly one access.
//   - cpu_stall tells the hazard logic to freeze the front of the pipeline.
//   - Read data returns one cycle after the granted read, steered to its owner.
// Optional feature macro: DMEM_BURST_EN
//   defined   : dma_burst lets the DMA keep ownership for up to BURST_MAX grants
//   undefined : dma_burst ignored, ownership FSM stays in IDLE
// Ports:
//   clk   rising-edge clock
//   reset synchronous active-high reset; all outputs forced to 0 while asserted
//   bus   dmem_arbiter_if.slave (CPU, DMA and memory sides)
module dmem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

`ifdef DMEM_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    localparam int               CNT_W     = $clog2(BURST_MAX + 1);
    localparam logic [3:0]       WAIT_LIM  = 4'(MAX_WAIT);
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

    typedef enum logic {
        IDLE,
        DMA_OWN
    } state_t;

    state_t           state, state_d;
    logic [3:0]       wait_cnt, wait_cnt_d;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_d;

    logic dma_win;
    logic cpu_gnt;
    logic dma_gnt;
    logic rd_vld_d;
    logic rd_vld_p1;
    logic rd_dma_p1;

    function automatic logic [3:0] wait_sat_inc(input logic [3:0] cnt);
        return (cnt >= WAIT_LIM) ? WAIT_LIM : cnt + 4'd1;
    endfunction

    function automatic logic [CNT_W-1:0] burst_sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt >= BURST_LIM) ? BURST_LIM : cnt + CNT_W'(1);
    endfunction

    // ---- stage p0: grant and memory command (combinational) ----
    always_comb begin
        dma_win = bus.dma_req &&
                  (wait_cnt == WAIT_LIM || !bus.cpu_req || state == DMA_OWN);
        // Reset blanks every output in the reset cycle, including the grants.
        dma_gnt = !reset && dma_win;
        cpu_gnt = !reset && bus.cpu_req && !dma_win;

        bus.dma_gnt   = dma_gnt;
        bus.cpu_stall = !reset && bus.cpu_req && !cpu_gnt;

        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (dma_gnt) begin
            bus.mem_re    = !bus.dma_we;
            bus.mem_we    = bus.dma_we;
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
        end else if (cpu_gnt) begin
            bus.mem_re    = !bus.cpu_we;
            bus.mem_we    = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end

        rd_vld_d = (cpu_gnt && !bus.cpu_we) || (dma_gnt && !bus.dma_we);
    end

    // Starvation counter and burst-ownership FSM next state.
    always_comb begin
        if (!bus.dma_req || dma_gnt) wait_cnt_d = 4'd0;
        else                         wait_cnt_d = wait_sat_inc(wait_cnt);

        state_d     = state;
        burst_cnt_d = burst_cnt;
        case (state)
            IDLE: begin
                burst_cnt_d = '0;
                // The entering grant is the first of the burst.
                if (BURST_EN && dma_gnt && bus.dma_burst && BURST_LIM > CNT_W'(1)) begin
                    state_d     = DMA_OWN;
                    burst_cnt_d = CNT_W'(1);
                end
            end
            DMA_OWN: begin
                if (dma_gnt && bus.dma_burst && burst_sat_inc(burst_cnt) < BURST_LIM) begin
                    burst_cnt_d = burst_sat_inc(burst_cnt);
                end else begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            burst_cnt <= '0;
            rd_vld_p1 <= 1'b0;
        end else begin
            state     <= state_d;
            wait_cnt  <= wait_cnt_d;
            burst_cnt <= burst_cnt_d;
            rd_vld_p1 <= rd_vld_d;
        end
    end

    // Owner tag is only meaningful while rd_vld_p1 is set.
    always_ff @(posedge clk) begin
        rd_dma_p1 <= dma_gnt;
    end

    // ---- stage p1: read return ----
    always_comb begin
        bus.cpu_rvalid = !reset && rd_vld_p1 && !rd_dma_p1;
        bus.dma_rvalid = !reset && rd_vld_p1 && rd_dma_p1;
        bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
        bus.dma_rdata  = bus.dma_rvalid ? bus.mem_rdata : '0;
    end

endmodule
